// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, RNONE and the
// hazard-controller state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Single saturating event counter; holds at all-ones once full.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 five-stage pipeline hazard controller with sticky halt FSM.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the saturating performance counters.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int ICODE_W     = 4,
  parameter int REG_W       = 4,
  parameter int STAT_W      = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_Cnd,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  input  logic               dmem_ready,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_stall,
  output logic               M_bubble,
  output logic               W_stall,
  output logic               W_bubble,
  output logic               halted,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   perf_stall_cnt,
  output logic [CNT_W-1:0]   perf_loaduse_cnt,
  output logic [CNT_W-1:0]   perf_mispred_cnt,
  output logic [CNT_W-1:0]   perf_ret_cnt,
  output logic [CNT_W-1:0]   perf_memwait_cnt
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  function automatic logic icode_is(input logic [ICODE_W-1:0] ic, input logic [3:0] k);
    return ic == ICODE_W'(k);
  endfunction

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(S_ADR)) || (s == STAT_W'(S_INS)) || (s == STAT_W'(S_HLT));
  endfunction

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;

  logic load_use, ret_pend, mispred, exc_m, exc_w, mem_req, mem_wait;

  assign load_use = (icode_is(E_icode, I_MRMOVQ) || icode_is(E_icode, I_POPQ)) &&
                    (E_dstM != '1) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_pend = icode_is(D_icode, I_RET) || icode_is(E_icode, I_RET) ||
                    icode_is(M_icode, I_RET);
  assign mispred  = icode_is(E_icode, I_JXX) && !e_Cnd;
  assign exc_m    = is_exc(m_stat);
  assign exc_w    = is_exc(W_stat);
  assign mem_req  = icode_is(M_icode, I_RMMOVQ) || icode_is(M_icode, I_MRMOVQ) ||
                    icode_is(M_icode, I_PUSHQ)  || icode_is(M_icode, I_POPQ)   ||
                    icode_is(M_icode, I_CALL)   || icode_is(M_icode, I_RET);
  assign mem_wait = mem_req && !dmem_ready && (m_stat == STAT_W'(S_AOK)) &&
                    (state_q != ST_HALT);

  // The wait counter only advances on genuinely waiting cycles, so the
  // timeout compare fires on the last permitted MEMWAIT cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_MEMWAIT;
          wait_d  = '0;
        end
      end
      ST_MEMWAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (mem_wait) begin
          if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            state_d = ST_HALT;
            tmo_d   = 1'b1;
          end else begin
            wait_d = wait_q + WCNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (exc_w && (state_q != ST_HALT)) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign mem_timeout = tmo_q;

  // A W-stage exception releases the M-stage stall so the bubble can take effect.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_stall  = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    if (!rst_n) begin
      F_stall = 1'b0;
    end else if (state_q == ST_HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = load_use | ret_pend | mem_wait;
      D_stall  = load_use | mem_wait;
      D_bubble = !mem_wait & (mispred | (!load_use & ret_pend)) & !D_stall;
      E_bubble = !mem_wait & (mispred | load_use);
      M_stall  = mem_wait & !exc_w;
      M_bubble = (exc_m | exc_w) & !M_stall;
      W_stall  = exc_w;
      W_bubble = mem_wait & !exc_w;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic cnt_en;
  assign cnt_en = (state_q != ST_HALT);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cnt_en & F_stall), .cnt_o(perf_stall_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_loaduse_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cnt_en & load_use), .cnt_o(perf_loaduse_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cnt_en & mispred), .cnt_o(perf_mispred_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cnt_en & ret_pend & D_bubble), .cnt_o(perf_ret_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cnt_en & mem_wait), .cnt_o(perf_memwait_cnt)
  );
`else
  assign perf_stall_cnt   = '0;
  assign perf_loaduse_cnt = '0;
  assign perf_mispred_cnt = '0;
  assign perf_ret_cnt     = '0;
  assign perf_memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=8; counter expectations
// follow PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, E_icode, M_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;
  logic        dmem_ready;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, W_bubble;
  logic        halted, mem_timeout;
  logic [31:0] perf_stall_cnt, perf_loaduse_cnt, perf_mispred_cnt, perf_ret_cnt, perf_memwait_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .ICODE_W(4), .REG_W(4), .STAT_W(3), .MEM_TIMEOUT(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
    .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat), .dmem_ready(dmem_ready),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble),
    .halted(halted), .mem_timeout(mem_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_loaduse_cnt(perf_loaduse_cnt),
    .perf_mispred_cnt(perf_mispred_cnt), .perf_ret_cnt(perf_ret_cnt),
    .perf_memwait_cnt(perf_memwait_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] di, input logic [3:0] ei, input logic [3:0] mi,
                               input logic [3:0] dstm, input logic [3:0] sb,
                               input logic cnd, input logic rdy);
    D_icode    = di;
    E_icode    = ei;
    M_icode    = mi;
    E_dstM     = dstm;
    d_srcB     = sb;
    e_Cnd      = cnd;
    dmem_ready = rdy;
  endtask

  // Packs the eight controls as {F_stall,D_stall,D_bubble,E_bubble,M_stall,M_bubble,W_stall,W_bubble}.
  function automatic logic [7:0] ctl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, W_bubble};
  endfunction

  initial begin
    rst_n  = 1'b0;
    d_srcA = 4'hF;
    m_stat = 3'd1;
    W_stat = 3'd1;
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 1'b1, 1'b1);
    #3;
    checkOutput("reset_ctl", ctl(), 8'h00);
    checkOutput("reset_halted", halted, 1'b0);
    checkOutput("reset_tmo", mem_timeout, 1'b0);
    checkOutput("reset_cnt", perf_stall_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("loaduse_ctl", ctl(), 8'b1101_0000);
    tick();
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("loaduse_gone", ctl(), 8'h00);
    applyStimulus(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("rnone_nostall", ctl(), 8'h00);
    tick();

    applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 1'b0, 1'b1);
    #1;
    checkOutput("mispred_ctl", ctl(), 8'b0011_0000);
    tick();
    applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("taken_ctl", ctl(), 8'h00);
    checkOutput("mispred_cnt", perf_mispred_cnt, PERF ? 1 : 0);
    tick();

    applyStimulus(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("ret_D", ctl(), 8'b1010_0000);
    tick();
    applyStimulus(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("ret_E", ctl(), 8'b1010_0000);
    tick();
    applyStimulus(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("ret_M", ctl(), 8'b1010_0000);
    tick();
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    #1;
    checkOutput("ret_done", ctl(), 8'h00);
    checkOutput("ret_cnt", perf_ret_cnt, PERF ? 3 : 0);

    applyStimulus(4'h1, 4'h1, 4'h5, 4'hF, 4'hF, 1'b1, 1'b0);
    #1;
    checkOutput("mwait_c1", ctl(), 8'b1100_1001);
    tick();
    applyStimulus(4'h1, 4'h5, 4'h5, 4'h3, 4'h3, 1'b1, 1'b0);
    #1;
    checkOutput("mwait_c2_loaduse", ctl(), 8'b1100_1001);
    tick();
    applyStimulus(4'h1, 4'h1, 4'h5, 4'hF, 4'hF, 1'b1, 1'b0);
    #1;
    checkOutput("mwait_c3", ctl(), 8'b1100_1001);
    tick();
    checkOutput("mwait_c4", ctl(), 8'b1100_1001);
    tick();
    dmem_ready = 1'b1;
    #1;
    checkOutput("mwait_ready", ctl(), 8'h00);
    tick();
    M_icode = 4'h1;
    #1;
    checkOutput("mwait_resume_halted", halted, 1'b0);
    checkOutput("memwait_cnt", perf_memwait_cnt, PERF ? 4 : 0);
    checkOutput("loaduse_cnt", perf_loaduse_cnt, PERF ? 2 : 0);

    applyStimulus(4'h1, 4'h1, 4'h5, 4'hF, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("tmo_before", {halted, mem_timeout}, 2'b00);
    checkOutput("tmo_before_ctl", ctl(), 8'b1100_1001);
    tick();
    checkOutput("tmo_pulse", {halted, mem_timeout}, 2'b11);
    checkOutput("halt_ctl", ctl(), 8'b1101_0110);
    tick();
    checkOutput("tmo_after", {halted, mem_timeout}, 2'b10);
    checkOutput("halt_ctl_persist", ctl(), 8'b1101_0110);
    checkOutput("stall_cnt_frozen", perf_stall_cnt, PERF ? 17 : 0);
    checkOutput("memwait_cnt_frozen", perf_memwait_cnt, PERF ? 13 : 0);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_halted", {halted, mem_timeout}, 2'b00);
    checkOutput("async_rst_ctl", ctl(), 8'h00);
    checkOutput("async_rst_cnt", perf_stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    m_stat = 3'd4;
    #1;
    checkOutput("exc_m_ctl", ctl(), 8'b0000_0100);
    tick();
    checkOutput("exc_m_nohalt", halted, 1'b0);

    m_stat = 3'd1;
    #1;
    checkOutput("exc_wait_c1", ctl(), 8'b1100_1001);
    tick();
    W_stat = 3'd3;
    #1;
    checkOutput("exc_w_over_wait", ctl(), 8'b1100_0110);
    checkOutput("exc_w_not_halted_yet", halted, 1'b0);
    tick();
    checkOutput("exc_w_halted", {halted, mem_timeout}, 2'b10);
    W_stat = 3'd1;
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b1);
    tick();
    checkOutput("halt_sticky", halted, 1'b1);
    checkOutput("halt_sticky_ctl", ctl(), 8'b1101_0110);
    checkOutput("exc_memwait_cnt", perf_memwait_cnt, PERF ? 2 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
